data_pack_datapath: RTL and testbench

DATA_PACK_DATAPATH -- requirements
Module: data_pack_datapath

---
 rtl/data_pack_pkg.sv | 15 +
 rtl/data_pack_outreg.sv | 62 ++++++
 rtl/data_pack_datapath.sv | 84 ++++++++
 tb/tb_data_pack_datapath.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/data_pack_pkg.sv
// Shared widths and types for the packet-to-word packer.
package data_pack_pkg;

    localparam int PKT_W  = 7;
    localparam int WORD_W = 32;
    localparam int FILL_W = $clog2(WORD_W);      // fill range 0..WORD_W-1
    localparam int BITS_W = $clog2(WORD_W + 1);  // word_bits range 1..WORD_W
    localparam int SUM_W  = FILL_W + 1;          // fill + PKT_W without overflow

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/data_pack_outreg.sv
// Output word register with valid/ready handshake.
//
// state     | meaning
// ----------+-------------------------------------------------
// OUT_EMPTY | no word held; register free for a load
// OUT_FULL  | word_out/word_bits valid, waiting for word_ready
module data_pack_outreg
    import data_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic [BITS_W-1:0] i_bits,
    input  logic              i_word_ready,
    output logic [WORD_W-1:0] o_word,
    output logic [BITS_W-1:0] o_bits,
    output logic              o_valid,
    output logic              o_free
);

    out_state_t        r_state;
    out_state_t        w_state_next;
    logic [WORD_W-1:0] r_word;
    logic [BITS_W-1:0] r_bits;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a load always leaves us full; a consume without a load empties.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OUT_EMPTY: if (i_load) w_state_next = OUT_FULL;
            OUT_FULL:  if (i_word_ready && !i_load) w_state_next = OUT_EMPTY;
            default:   w_state_next = OUT_EMPTY;
        endcase
    end

    // Payload capture; the caller only loads while the register is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_bits <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_bits <= i_bits;
        end
    end

    assign o_word  = r_word;
    assign o_bits  = r_bits;
    assign o_valid = (r_state == OUT_FULL);
    assign o_free  = (r_state == OUT_EMPTY) || i_word_ready;

endmodule

// File: rtl/data_pack_datapath.sv
// Packs fixed-width packets into an MSB-first continuous bitstream of words,
// with a flush that emits the partial word zero-padded.
module data_pack_datapath #(
    parameter int PKT_W  = data_pack_pkg::PKT_W,
    parameter int WORD_W = data_pack_pkg::WORD_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PKT_W-1:0]                 pkt_in,
    input  logic                             pkt_valid,
    output logic                             pkt_ready,
    input  logic                             flush,
    output logic [WORD_W-1:0]                word_out,
    output logic [data_pack_pkg::BITS_W-1:0] word_bits,
    output logic                             word_valid,
    input  logic                             word_ready,
    output logic [data_pack_pkg::FILL_W-1:0] fill
);

    import data_pack_pkg::*;

    logic [WORD_W-1:0]       r_acc;
    logic [FILL_W-1:0]       r_fill;

    logic [SUM_W-1:0]        w_sum;
    logic                    w_fits;
    logic                    w_free;
    logic                    w_accept;
    logic                    w_flush_go;
    logic                    w_load;
    logic [WORD_W+PKT_W-1:0] w_wide;
    logic [WORD_W-1:0]       w_load_word;
    logic [BITS_W-1:0]       w_load_bits;

    assign w_sum  = {1'b0, r_fill} + SUM_W'(PKT_W);
    assign w_fits = (w_sum < SUM_W'(WORD_W));

    // Accumulator extended by one packet of spill room: the top WORD_W bits are
    // the word-so-far, the low PKT_W bits hold any overflow left-aligned.
    assign w_wide = {r_acc, {PKT_W{1'b0}}} | ({pkt_in, {WORD_W{1'b0}}} >> r_fill);

    assign pkt_ready  = !rst && !flush && (w_fits || w_free);
    assign w_accept   = pkt_valid && pkt_ready;
    assign w_flush_go = flush && (r_fill != '0) && w_free;
    assign w_load     = w_flush_go || (w_accept && !w_fits);

    assign w_load_word = w_flush_go ? r_acc : w_wide[WORD_W+PKT_W-1:PKT_W];
    assign w_load_bits = w_flush_go ? BITS_W'(r_fill) : BITS_W'(WORD_W);

    // Accumulator and fill update; on a completing accept the truncated sum is
    // exactly fill+PKT_W-WORD_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (w_flush_go) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            if (w_fits) begin
                r_acc <= w_wide[WORD_W+PKT_W-1:PKT_W];
            end else begin
                r_acc <= {w_wide[PKT_W-1:0], {(WORD_W-PKT_W){1'b0}}};
            end
            r_fill <= w_sum[FILL_W-1:0];
        end
    end

    data_pack_outreg u_outreg (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_word       (w_load_word),
        .i_bits       (w_load_bits),
        .i_word_ready (word_ready),
        .o_word       (word_out),
        .o_bits       (word_bits),
        .o_valid      (word_valid),
        .o_free       (w_free)
    );

    assign fill = r_fill;

endmodule

// File: tb/tb_data_pack_datapath.sv
// Bench for data_pack_datapath: bit-queue reference model plus directed vectors.
module tb_data_pack_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  pkt_in = '0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic        flush = 1'b0;
    logic [31:0] word_out;
    logic [5:0]  word_bits;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [4:0]  fill;

    always #5 clk = ~clk;

    data_pack_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_in     (pkt_in),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .flush      (flush),
        .word_out   (word_out),
        .word_bits  (word_bits),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fill       (fill)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: pending stream bits in order, plus one output slot.
    bit          mq[$];
    bit          slot_v = 1'b0;
    logic [31:0] slot_w = '0;
    logic [5:0]  slot_b = '0;
    int          words_loaded = 0;
    bit          all_ones = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        slot_v = 1'b0;
        slot_w = '0;
        slot_b = '0;
    endtask

    // One clock: drive inputs, check all outputs against the model at the
    // falling edge, then advance the model with what the rising edge commits.
    task automatic step(input bit pv, input logic [6:0] pkt, input bit fl, input bit wr);
        bit          free;
        bit          fits;
        bit          rdy;
        bit          fgo;
        bit          acc;
        logic [31:0] w;
        int          n;
        pkt_valid  = pv;
        pkt_in     = pkt;
        flush      = fl;
        word_ready = wr;
        @(negedge clk);
        free = !slot_v || wr;
        fits = (mq.size() + 7) < 32;
        rdy  = !fl && (fits || free);
        fgo  = fl && (mq.size() > 0) && free;
        acc  = pv && rdy;
        chk("pkt_ready", 32'(pkt_ready), 32'(rdy));
        chk("word_valid", 32'(word_valid), 32'(slot_v));
        chk("fill", 32'(fill), 32'(mq.size()));
        if (slot_v) begin
            chk("word_out", word_out, slot_w);
            chk("word_bits", 32'(word_bits), 32'(slot_b));
        end
        if (slot_v && wr) slot_v = 1'b0;
        if (fgo) begin
            n = mq.size();
            w = '0;
            for (int i = 0; i < n; i++) w = {w[30:0], mq.pop_front()};
            w = w << (32 - n);
            slot_w = w;
            slot_b = n[5:0];
            slot_v = 1'b1;
            words_loaded++;
        end else if (acc) begin
            for (int b = 6; b >= 0; b--) mq.push_back(pkt[b]);
            if (mq.size() >= 32) begin
                w = '0;
                for (int i = 0; i < 32; i++) w = {w[30:0], mq.pop_front()};
                slot_w = w;
                slot_b = 6'd32;
                slot_v = 1'b1;
                words_loaded++;
                if (w != 32'hFFFF_FFFF) all_ones = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        pkt_valid  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_out", word_out, 32'd0);
        chk("rst_word_bits", 32'(word_bits), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_pkt_ready", 32'(pkt_ready), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Five small packets complete one word, three bits left over.
        for (int p = 1; p <= 5; p++) step(1'b1, 7'(p), 1'b0, 1'b1);
        chk("vec1_valid", 32'(word_valid), 32'd1);
        chk("vec1_word", word_out, 32'h0208_1840);
        chk("vec1_bits", 32'(word_bits), 32'd32);
        chk("vec1_fill", 32'(fill), 32'd3);

        // Flush the three leftover bits.
        step(1'b0, 7'd0, 1'b1, 1'b1);
        chk("vec2_word", word_out, 32'hA000_0000);
        chk("vec2_bits", 32'(word_bits), 32'd3);
        chk("vec2_fill", 32'(fill), 32'd0);

        // 32 all-ones packets: exactly seven full words, ready never drops.
        words_loaded = 0;
        all_ones     = 1'b1;
        repeat (32) step(1'b1, 7'h7F, 1'b0, 1'b1);
        chk("ones_words", 32'(words_loaded), 32'd7);
        chk("ones_value", 32'(all_ones), 32'd1);
        chk("ones_fill", 32'(fill), 32'd0);
        step(1'b0, 7'd0, 1'b0, 1'b1);

        // Backpressure: first word held, accumulator fills to 31 then stalls.
        do_reset();
        repeat (10) step(1'b1, 7'($urandom), 1'b0, 1'b0);
        pkt_valid = 1'b1;
        #1;
        chk("stall_ready", 32'(pkt_ready), 32'd0);
        chk("stall_fill", 32'(fill), 32'd31);
        chk("stall_valid", 32'(word_valid), 32'd1);
        repeat (8) step(1'b1, 7'($urandom), 1'b0, 1'b1);
        repeat (3) step(1'b0, 7'd0, 1'b1, 1'b1);

        // Flush and packet together at fill 14: flush wins, packet goes next.
        do_reset();
        repeat (2) step(1'b1, 7'($urandom), 1'b0, 1'b1);
        step(1'b1, 7'h55, 1'b1, 1'b1);
        chk("prio_valid", 32'(word_valid), 32'd1);
        chk("prio_bits", 32'(word_bits), 32'd14);
        chk("prio_fill", 32'(fill), 32'd0);
        step(1'b1, 7'h55, 1'b0, 1'b1);
        chk("prio_fill2", 32'(fill), 32'd7);
        step(1'b0, 7'd0, 1'b1, 1'b1);
        chk("prio_word", word_out, 32'hAA00_0000);
        chk("prio_bits2", 32'(word_bits), 32'd7);

        // Reset at fill 17 with a word pending discards everything.
        do_reset();
        repeat (7) step(1'b1, 7'($urandom), 1'b0, 1'b0);
        chk("pre_rst_fill", 32'(fill), 32'd17);
        chk("pre_rst_valid", 32'(word_valid), 32'd1);
        do_reset();
        for (int p = 1; p <= 5; p++) step(1'b1, 7'(p), 1'b0, 1'b1);
        chk("post_rst_word", word_out, 32'h0208_1840);
        chk("post_rst_fill", 32'(fill), 32'd3);

        // Random traffic against the model.
        repeat (600) begin
            step(($urandom % 4) != 0, 7'($urandom), ($urandom % 16) == 0,
                 ($urandom % 3) != 0);
        end
        repeat (3) step(1'b0, 7'd0, 1'b1, 1'b1);
        step(1'b0, 7'd0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
